control_riego: RTL and testbench
================================

# control_riego

Watering-decision stage that sits directly upstream of the pump controller. It collects humidity samples from the soil-sensor module and averages each group of four. When the average falls below the dry threshold, it raises `regar` and holds it until the pump acknowledges through its `activarB` feedback. After the pump stops, it enforces a soak lock-out before evaluating humidity again, and it flags sensor and pump faults.

## Interface
- `UMBRAL`, default 20: dry threshold in percent; a request is issued when avg < UMBRAL (strict).
- `ACK_CICLOS`, default 16: cycles `regar` may stay high without `bomba_activa` before a pump fault.
- `TIMEOUT_CICLOS`, default 64'd100_000_000: cycles without a valid sample before a sensor fault.
- `ESPERA_CICLOS`, default 64'd15_000_000_000: soak lock-out after watering (5 min at 50 MHz).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `MODsensor`  in  1  sensor module connected.
- `humedad`  in  7  humidity in percent; legal range 0..100.
- `humedad_valida`  in  1  one-cycle strobe qualifying `humedad`.
- `bomba_activa`  in  1  pump running (driven from the pump's `activarB`).
- `regar`  out  1  watering request to the pump.
- `humedad_prom`  out  7  last computed 4-sample average.
- `error_sensor`  out  1  sensor fault: out-of-range sample or timeout.
- `error_bomba`  out  1  pump did not acknowledge a request (sticky).
- `estado`  out  2  state: 0 MUESTREO, 1 SOLICITAR, 2 REGANDO, 3 ESPERA.

## Operation
- **Reset values:** `rst`=1 asynchronously forces `regar`=0, `humedad_prom`=0, `error_sensor`=0, `error_bomba`=0, `estado`=MUESTREO, and clears the accumulator and all counters.
- **MUESTREO, sample handling:**
  - On a `humedad_valida` strobe with `humedad`≤100: add the value to a 9-bit sum, increment a 2-bit sample count, clear `error_sensor`, and clear the timeout counter.
  - On a strobe with `humedad`>100: discard the sample, set `error_sensor`=1, and leave the count and sum unchanged.
- **MUESTREO, average and decision:**
  - On the 4th accepted sample: `humedad_prom` = (sum + sample) >> 2, truncated.
  - The comparison uses this new value.
  - If avg < UMBRAL, go to SOLICITAR with `regar`=1; otherwise stay in MUESTREO.
  - In both cases clear the sum and count.
- **MUESTREO, timeout:** the timeout counter increments every cycle without a strobe. When it reaches TIMEOUT_CICLOS, set `error_sensor`=1, clear the partial sum and count, and restart the counter.
- **SOLICITAR:**
  - `regar` stays high and the ack counter increments.
  - If `bomba_activa`=1 is sampled, go to REGANDO with `regar`=0.
  - If the ack counter reaches ACK_CICLOS first, set `error_bomba`=1, set `regar`=0, and return to MUESTREO.
- **REGANDO:** `regar`=0. On the first sampled `bomba_activa`=0, go to ESPERA and load the soak counter.
- **ESPERA:** strobes are ignored and the timeout counter is idle. After ESPERA_CICLOS cycles, go to MUESTREO with the accumulator cleared.
- **`MODsensor`=0:**
  - In MUESTREO or SOLICITAR: force MUESTREO, set `regar`=0, and clear the accumulator and timeout counter. No timeout fault is raised while disconnected.
  - In REGANDO or ESPERA: no effect; those phases complete normally.
- `error_bomba` is cleared only by `rst`.

## Timing
- `regar`, `humedad_prom`, `estado`, and both error flags are registered outputs.
- A 4th-sample strobe in cycle N produces `humedad_prom` and `regar` valid in cycle N+1: latency 1.
- The pump's `activarB` follows `regar` by 2 cycles, so a nominal ack arrives well inside ACK_CICLOS.
- Exact ack boundary: if `bomba_activa` rises on the same edge the ack counter hits ACK_CICLOS, the ack wins (go to REGANDO, no fault).
- `regar` drops on the edge that samples `bomba_activa`=1. The pump has already latched the request by then, so no retrigger occurs.
- A strobe coinciding with `MODsensor` falling is discarded.
- The sample count wraps 3→0 only through the decision step; a 5th sample never accumulates into the previous group.
- Reset asserted mid-watering drops `regar` immediately. `bomba_activa` is ignored until a new request is issued.

## Test plan
- **Dry soil:** reset, then strobes 10,12,14,16 → `humedad_prom`=13 one cycle after the 4th strobe; `regar`=1 and `estado`=1 on that cycle.
- **Wet soil and boundary:** strobes 50,50,50,50 → `humedad_prom`=50, `regar` stays 0. Strobes 20,20,20,21 → avg 20, no request (strict compare).
- **Handshake and soak:**
  - Model the pump: `bomba_activa` rises 2 cycles after `regar`, lasts 100 cycles.
  - Expected: `regar` falls when `bomba_activa` is seen, then REGANDO → ESPERA.
  - During ESPERA (ESPERA_CICLOS=1000), dry strobes produce no `regar`.
  - After ESPERA, four dry samples → new request.
- **Pump absent:** `bomba_activa` held 0 → `regar` high for exactly 16 cycles, then `error_bomba`=1, `estado`=0.
- **Sensor faults:**
  - Strobe 120 → `error_sensor`=1 and sample count unchanged; a later strobe 30 clears `error_sensor`.
  - No strobes for TIMEOUT_CICLOS=50 → `error_sensor`=1 and partial sum discarded.
- **Disconnect and reset:**
  - `MODsensor`=0 during SOLICITAR → `regar`=0 next cycle, `estado`=0.
  - Async `rst` pulse mid-REGANDO (between clock edges) → all outputs 0 immediately.

Source files
------------

// File: rtl/control_riego_if.sv
`default_nettype none
// ============================================================================
// Module   : control_riego_if
// Brief    : Sensor/pump-facing signal bundle of the watering-decision stage.
// Revision : 1.0
// ============================================================================
interface control_riego_if;
    logic       MODsensor;
    logic [6:0] humedad;
    logic       humedad_valida;
    logic       bomba_activa;
    logic       regar;
    logic [6:0] humedad_prom;
    logic       error_sensor;
    logic       error_bomba;
    logic [1:0] estado;

    modport master (
        output MODsensor, humedad, humedad_valida, bomba_activa,
        input  regar, humedad_prom, error_sensor, error_bomba, estado
    );

    modport slave (
        input  MODsensor, humedad, humedad_valida, bomba_activa,
        output regar, humedad_prom, error_sensor, error_bomba, estado
    );
endinterface
`default_nettype wire

// File: rtl/control_riego.sv
`default_nettype none
// ============================================================================
// Module   : control_riego
// Brief    : Averages groups of four humidity samples, requests watering
//            below the dry threshold and enforces a soak lock-out afterwards.
// Revision : 1.0
// ============================================================================
module control_riego #(
    parameter int unsigned UMBRAL         = 20,
    parameter int unsigned ACK_CICLOS     = 16,
    parameter logic [63:0] TIMEOUT_CICLOS = 64'd100_000_000,
    parameter logic [63:0] ESPERA_CICLOS  = 64'd15_000_000_000
) (
    input  wire logic      clk,
    input  wire logic      rst,
    control_riego_if.slave bus
);

    typedef enum logic [1:0] {
        MUESTREO  = 2'd0,
        SOLICITAR = 2'd1,
        REGANDO   = 2'd2,
        ESPERA    = 2'd3
    } estado_t;

    localparam logic [6:0] c_umbral = 7'(UMBRAL);

    estado_t     r_estado, w_estado;
    logic [8:0]  r_sum, w_sum;
    logic [1:0]  r_cnt, w_cnt;
    logic [63:0] r_tout, w_tout;
    logic [31:0] r_ack, w_ack;
    logic [63:0] r_espera, w_espera;
    logic        r_regar, w_regar;
    logic [6:0]  r_prom, w_prom;
    logic        r_err_s, w_err_s;
    logic        r_err_b, w_err_b;
    logic [8:0]  w_total;
    logic [6:0]  w_avg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= MUESTREO;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_tout   <= '0;
            r_ack    <= '0;
            r_espera <= '0;
            r_regar  <= 1'b0;
            r_prom   <= '0;
            r_err_s  <= 1'b0;
            r_err_b  <= 1'b0;
        end else begin
            r_estado <= w_estado;
            r_sum    <= w_sum;
            r_cnt    <= w_cnt;
            r_tout   <= w_tout;
            r_ack    <= w_ack;
            r_espera <= w_espera;
            r_regar  <= w_regar;
            r_prom   <= w_prom;
            r_err_s  <= w_err_s;
            r_err_b  <= w_err_b;
        end
    end

    always_comb begin
        w_estado = r_estado;
        w_sum    = r_sum;
        w_cnt    = r_cnt;
        w_tout   = r_tout;
        w_ack    = r_ack;
        w_espera = r_espera;
        w_regar  = r_regar;
        w_prom   = r_prom;
        w_err_s  = r_err_s;
        w_err_b  = r_err_b;
        // Three accepted samples never exceed 300, so 9 bits hold the group sum.
        w_total  = r_sum + {2'b00, bus.humedad};
        w_avg    = w_total[8:2];

        case (r_estado)
            MUESTREO: begin
                w_regar = 1'b0;
                if (!bus.MODsensor) begin
                    w_sum  = '0;
                    w_cnt  = '0;
                    w_tout = '0;
                end else if (bus.humedad_valida) begin
                    if (bus.humedad > 7'd100) begin
                        w_err_s = 1'b1;
                    end else begin
                        w_err_s = 1'b0;
                        w_tout  = '0;
                        if (r_cnt == 2'd3) begin
                            w_prom = w_avg;
                            w_sum  = '0;
                            w_cnt  = '0;
                            if (w_avg < c_umbral) begin
                                w_estado = SOLICITAR;
                                w_regar  = 1'b1;
                                w_ack    = '0;
                            end
                        end else begin
                            w_sum = w_total;
                            w_cnt = r_cnt + 2'd1;
                        end
                    end
                end else if (r_tout + 64'd1 == TIMEOUT_CICLOS) begin
                    w_err_s = 1'b1;
                    w_sum   = '0;
                    w_cnt   = '0;
                    w_tout  = '0;
                end else begin
                    w_tout = r_tout + 64'd1;
                end
            end

            SOLICITAR: begin
                w_regar = 1'b1;
                if (!bus.MODsensor) begin
                    w_estado = MUESTREO;
                    w_regar  = 1'b0;
                    w_sum    = '0;
                    w_cnt    = '0;
                    w_tout   = '0;
                end else if (bus.bomba_activa) begin
                    // An ack on the same edge as the deadline still counts.
                    w_estado = REGANDO;
                    w_regar  = 1'b0;
                end else if (r_ack + 32'd1 == ACK_CICLOS) begin
                    w_err_b  = 1'b1;
                    w_regar  = 1'b0;
                    w_estado = MUESTREO;
                end else begin
                    w_ack = r_ack + 32'd1;
                end
            end

            REGANDO: begin
                w_regar = 1'b0;
                if (!bus.bomba_activa) begin
                    w_estado = ESPERA;
                    w_espera = ESPERA_CICLOS;
                end
            end

            ESPERA: begin
                w_regar = 1'b0;
                if (r_espera <= 64'd1) begin
                    w_estado = MUESTREO;
                    w_sum    = '0;
                    w_cnt    = '0;
                    w_tout   = '0;
                end else begin
                    w_espera = r_espera - 64'd1;
                end
            end

            default: begin
                w_estado = MUESTREO;
                w_regar  = 1'b0;
            end
        endcase
    end

    assign bus.regar        = r_regar;
    assign bus.humedad_prom = r_prom;
    assign bus.error_sensor = r_err_s;
    assign bus.error_bomba  = r_err_b;
    assign bus.estado       = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_control_riego.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_riego
// Brief    : Directed and randomized bench for control_riego against a
//            queue-based behavioural model of the watering rules.
// Revision : 1.0
// ============================================================================
module tb_control_riego;

    localparam int UMB  = 20;
    localparam int ACK  = 16;
    localparam int TOUT = 50;
    localparam int ESP  = 1000;

    localparam int P_SAMPLE = 0;
    localparam int P_REQ    = 1;
    localparam int P_WATER  = 2;
    localparam int P_SOAK   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    control_riego_if bus();

    control_riego #(
        .UMBRAL        (UMB),
        .ACK_CICLOS    (ACK),
        .TIMEOUT_CICLOS(64'(TOUT)),
        .ESPERA_CICLOS (64'(ESP))
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Behavioural model state
    int m_phase;
    int m_samples[$];
    int m_idle, m_age, m_soak, m_prom;
    bit m_regar, m_es, m_eb;

    // Pump stimulus state
    bit p_on;
    int p_len, p_run;
    bit p_wait, p_prev;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_SAMPLE;
        m_samples.delete();
        m_idle  = 0;
        m_age   = 0;
        m_soak  = 0;
        m_prom  = 0;
        m_regar = 1'b0;
        m_es    = 1'b0;
        m_eb    = 1'b0;
    endtask

    task automatic model_step();
        int sum;
        int avg;
        bit ms, hv, ba;
        int h;
        ms = bus.MODsensor;
        hv = bus.humedad_valida;
        ba = bus.bomba_activa;
        h  = int'(bus.humedad);
        case (m_phase)
            P_SAMPLE: begin
                if (!ms) begin
                    m_samples.delete();
                    m_idle = 0;
                end else if (hv) begin
                    if (h > 100) begin
                        m_es = 1'b1;
                    end else begin
                        m_es   = 1'b0;
                        m_idle = 0;
                        m_samples.push_back(h);
                        if (m_samples.size() == 4) begin
                            sum = 0;
                            foreach (m_samples[k]) sum += m_samples[k];
                            avg    = sum / 4;
                            m_prom = avg;
                            m_samples.delete();
                            if (avg < UMB) begin
                                m_phase = P_REQ;
                                m_regar = 1'b1;
                                m_age   = 0;
                            end
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TOUT) begin
                        m_es = 1'b1;
                        m_samples.delete();
                        m_idle = 0;
                    end
                end
            end
            P_REQ: begin
                if (!ms) begin
                    m_phase = P_SAMPLE;
                    m_regar = 1'b0;
                    m_samples.delete();
                    m_idle = 0;
                end else if (ba) begin
                    m_phase = P_WATER;
                    m_regar = 1'b0;
                end else begin
                    m_age++;
                    if (m_age == ACK) begin
                        m_eb    = 1'b1;
                        m_regar = 1'b0;
                        m_phase = P_SAMPLE;
                    end
                end
            end
            P_WATER: begin
                if (!ba) begin
                    m_phase = P_SOAK;
                    m_soak  = ESP;
                end
            end
            default: begin
                m_soak--;
                if (m_soak == 0) begin
                    m_phase = P_SAMPLE;
                    m_samples.delete();
                    m_idle = 0;
                end
            end
        endcase
    endtask

    // Pump answers a rising request two cycles later and runs p_len cycles.
    task automatic pump_step();
        if (p_run > 0) begin
            p_run--;
            if (p_run == 0) bus.bomba_activa = 1'b0;
        end else if (p_wait) begin
            p_wait           = 1'b0;
            bus.bomba_activa = 1'b1;
            p_run            = p_len;
        end else if (bus.regar && !p_prev && p_on) begin
            p_wait = 1'b1;
        end
        p_prev = bus.regar;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        bus.humedad_valida = 1'b0;
        pump_step();
    endtask

    task automatic strobe(input int v);
        bus.humedad        = 7'(v);
        bus.humedad_valida = 1'b1;
        tick();
    endtask

    task automatic wait_estado(input int want, input int maxc, input string nm);
        int n;
        n = 0;
        while (int'(bus.estado) != want && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, bus.estado, want);
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("regar",        bus.regar,        m_regar);
            chk("humedad_prom", bus.humedad_prom, m_prom);
            chk("error_sensor", bus.error_sensor, m_es);
            chk("error_bomba",  bus.error_bomba,  m_eb);
            chk("estado",       bus.estado,       m_phase);
        end
    end

    initial begin
        int n;
        int r;
        int v;
        bit quiet;

        bus.MODsensor      = 1'b1;
        bus.humedad        = '0;
        bus.humedad_valida = 1'b0;
        bus.bomba_activa   = 1'b0;
        p_on = 1'b1; p_len = 100; p_run = 0; p_wait = 1'b0; p_prev = 1'b0;
        quiet = 1'b0;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        chk("rst_regar",  bus.regar,        0);
        chk("rst_prom",   bus.humedad_prom, 0);
        chk("rst_err_s",  bus.error_sensor, 0);
        chk("rst_err_b",  bus.error_bomba,  0);
        chk("rst_estado", bus.estado,       0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Dry soil: (10+12+14+16)/4 = 13
        strobe(10); strobe(12); strobe(14); strobe(16);
        chk("dry_prom",   bus.humedad_prom, 13);
        chk("dry_regar",  bus.regar,        1);
        chk("dry_estado", bus.estado,       1);
        chk("model_dry_prom", m_prom,       13);

        // Handshake and soak
        wait_estado(2, 10, "to_regando");
        chk("regando_regar", bus.regar, 0);
        wait_estado(3, 200, "to_espera");
        for (int i = 0; i < 8; i++) begin
            strobe(5);
            chk("espera_no_regar", bus.regar, 0);
        end
        wait_estado(0, 1100, "espera_done");
        strobe(8); strobe(8); strobe(8); strobe(8);
        chk("post_espera_regar", bus.regar, 1);
        chk("post_espera_prom",  bus.humedad_prom, 8);
        wait_estado(0, 1300, "second_cycle_done");

        // Wet soil and strict threshold
        strobe(50); strobe(50); strobe(50); strobe(50);
        chk("wet_prom",  bus.humedad_prom, 50);
        chk("wet_regar", bus.regar, 0);
        strobe(20); strobe(20); strobe(20); strobe(21);
        chk("umbral_prom",  bus.humedad_prom, 20);
        chk("umbral_regar", bus.regar, 0);

        // Pump absent
        p_on = 1'b0;
        strobe(0); strobe(0); strobe(0); strobe(0);
        n = bus.regar ? 1 : 0;
        while (bus.regar && n < 40) begin
            tick();
            if (bus.regar) n++;
        end
        chk("ack_window", n, 16);
        chk("pump_fault", bus.error_bomba, 1);
        chk("pump_fault_estado", bus.estado, 0);

        // Out-of-range sample is discarded: (10+10+10+30)/4 = 15
        strobe(10); strobe(10); strobe(10);
        strobe(120);
        chk("range_err", bus.error_sensor, 1);
        strobe(30);
        chk("range_clear", bus.error_sensor, 0);
        chk("range_prom",  bus.humedad_prom, 15);
        chk("range_req",   bus.estado, 1);

        // Disconnect during request
        bus.MODsensor = 1'b0;
        tick();
        chk("disc_regar",  bus.regar, 0);
        chk("disc_estado", bus.estado, 0);
        bus.MODsensor = 1'b1;
        tick();

        // Timeout discards the partial group
        strobe(90); strobe(90);
        repeat (TOUT - 1) tick();
        chk("tout_early", bus.error_sensor, 0);
        tick();
        chk("tout_err", bus.error_sensor, 1);
        strobe(40); strobe(40); strobe(40); strobe(40);
        chk("tout_prom",  bus.humedad_prom, 40);
        chk("tout_clear", bus.error_sensor, 0);

        // Asynchronous reset mid-watering
        p_on = 1'b1; p_len = 100;
        strobe(0); strobe(0); strobe(0); strobe(0);
        wait_estado(2, 10, "pre_reset_regando");
        repeat (5) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_regar",  bus.regar,        0);
        chk("arst_prom",   bus.humedad_prom, 0);
        chk("arst_err_s",  bus.error_sensor, 0);
        chk("arst_err_b",  bus.error_bomba,  0);
        chk("arst_estado", bus.estado,       0);
        tick();
        rst = 1'b0;
        repeat (120) tick();

        // Randomized traffic
        for (int i = 0; i < 15000; i++) begin
            if (p_run == 0 && !p_wait && !bus.regar) begin
                p_on  = ($urandom_range(0, 7) != 0);
                p_len = $urandom_range(1, 30);
            end
            if (i % 300 == 0) quiet = ($urandom_range(0, 3) == 0);
            if (bus.MODsensor) begin
                if ($urandom_range(0, 299) == 0) bus.MODsensor = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.MODsensor = 1'b1;
            end
            if (!quiet && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 99);
                if (r < 70)      v = $urandom_range(0, 40);
                else if (r < 95) v = $urandom_range(41, 100);
                else             v = $urandom_range(101, 127);
                bus.humedad        = 7'(v);
                bus.humedad_valida = 1'b1;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
